// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: MSB-first serial-to-byte receiver; aligns on the comma byte and flags idle commas.
// Optional lock-loss timeout: define SP_LOCK_TIMEOUT_EN.
module serial_paralelo_rx #(
   parameter logic [7:0]  COMMA         = 8'hBC,
   parameter int unsigned COMMA_COUNT   = 4,
   parameter int unsigned TIMEOUT_BYTES = 16
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       byte_strobe,
   output logic       active
);
   localparam int unsigned BC_W = $clog2(COMMA_COUNT + 1);
   localparam logic [BC_W-1:0] BC_MAX = BC_W'(COMMA_COUNT);

   typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

   state_t          r_state, w_state_nxt;
   logic [7:0]      r_shift;
   logic [2:0]      r_bit_cnt, w_bit_cnt_nxt;
   logic [BC_W-1:0] r_bc_cnt, w_bc_nxt, w_bc_inc;
   logic [7:0]      r_data_out, w_data_nxt;
   logic            r_valid_out, w_valid_nxt;
   logic            r_strobe, w_strobe_nxt;
   logic            r_active, w_active_nxt;

   logic [7:0]      w_shift_nxt;
   logic            w_boundary;
   logic            w_is_comma;

`ifdef SP_LOCK_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_BYTES + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_BYTES);
   logic [TO_W-1:0] r_nc_cnt, w_nc_nxt, w_nc_inc;
   assign w_nc_inc = r_nc_cnt + TO_W'(1);
`else
   logic w_cfg_unused;
   assign w_cfg_unused = (TIMEOUT_BYTES == 0);
`endif

   assign w_shift_nxt = {r_shift[6:0], data_in};
   assign w_boundary  = (r_bit_cnt == 3'd7);
   assign w_is_comma  = (w_shift_nxt == COMMA);
   assign w_bc_inc    = r_bc_cnt + BC_W'(1);

   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt + 3'd1;
      w_bc_nxt      = r_bc_cnt;
      w_data_nxt    = r_data_out;
      w_valid_nxt   = r_valid_out;
      w_strobe_nxt  = 1'b0;
      w_active_nxt  = r_active;
`ifdef SP_LOCK_TIMEOUT_EN
      w_nc_nxt      = r_nc_cnt;
`endif
      unique case (r_state)
         SEARCH: begin
            // Sliding match: the comma's last bit becomes the new byte boundary.
            if (w_is_comma) begin
               w_bit_cnt_nxt = 3'd0;
               w_bc_nxt      = BC_W'(1);
               if (COMMA_COUNT == 1) begin
                  w_state_nxt  = LOCKED;
                  w_active_nxt = 1'b1;
               end else begin
                  w_state_nxt  = ALIGN;
               end
            end
         end
         ALIGN: begin
            if (w_boundary) begin
               if (w_is_comma) begin
                  w_bc_nxt = w_bc_inc;
                  if (w_bc_inc == BC_MAX) begin
                     w_state_nxt  = LOCKED;
                     w_active_nxt = 1'b1;
                  end
               end else begin
                  w_state_nxt = SEARCH;
                  w_bc_nxt    = '0;
               end
            end
         end
         LOCKED: begin
            if (w_boundary) begin
               w_data_nxt   = w_shift_nxt;
               w_valid_nxt  = !w_is_comma;
               w_strobe_nxt = 1'b1;
`ifdef SP_LOCK_TIMEOUT_EN
               // The timing-out byte is still delivered before lock drops.
               if (w_is_comma) begin
                  w_nc_nxt = '0;
               end else if (w_nc_inc == TO_MAX) begin
                  w_state_nxt   = SEARCH;
                  w_active_nxt  = 1'b0;
                  w_nc_nxt      = '0;
                  w_bc_nxt      = '0;
                  w_bit_cnt_nxt = 3'd0;
               end else begin
                  w_nc_nxt = w_nc_inc;
               end
`endif
            end
         end
         default: w_state_nxt = SEARCH;
      endcase
   end

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         r_state     <= SEARCH;
         r_shift     <= 8'h00;
         r_bit_cnt   <= 3'd0;
         r_bc_cnt    <= '0;
         r_data_out  <= 8'h00;
         r_valid_out <= 1'b0;
         r_strobe    <= 1'b0;
         r_active    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_bc_cnt    <= w_bc_nxt;
         r_data_out  <= w_data_nxt;
         r_valid_out <= w_valid_nxt;
         r_strobe    <= w_strobe_nxt;
         r_active    <= w_active_nxt;
      end
   end

`ifdef SP_LOCK_TIMEOUT_EN
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) r_nc_cnt <= '0;
      else        r_nc_cnt <= w_nc_nxt;
   end
`endif

   assign data_out    = r_data_out;
   assign valid_out   = r_valid_out;
   assign byte_strobe = r_strobe;
   assign active      = r_active;

endmodule
